// File: rtl/hex_display_driver.sv
// Drives four active-low 7-segment digits from a PIO control word.
// Provides hex decode, enable, blink and PWM brightness, with the word shadowed at PWM frame boundaries.
module hex_display_driver #(
    parameter int unsigned BLINK_DIV = 25000000,
    parameter int unsigned BLINK_W   = 25
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pio_word,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic        frame_tick
);

    localparam int unsigned DIGITS = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned PWM_W  = 4;

    localparam logic [SEG_W-1:0]   SEG_OFF    = 7'h7F;
    localparam logic [PWM_W-1:0]   PWM_LAST   = '1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    typedef struct packed {
        logic [3:0]  rsvd;
        logic [3:0]  bright;
        logic [3:0]  blink;
        logic [3:0]  en;
        logic [15:0] nib;
    } ctrl_t;

    ctrl_t              shadow_q;
    logic [PWM_W-1:0]   pwm_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_ph;
    logic [DIGITS-1:0]  lit_c;
    logic [SEG_W-1:0]   seg_c [DIGITS];
    logic               unused_rsvd;

    assign unused_rsvd = ^shadow_q.rsvd;

    function automatic logic [SEG_W-1:0] seg7(input logic [NIB_W-1:0] nib);
        logic [SEG_W-1:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // PWM frame counter; the PIO word is captured only on the last slot so a frame never tears
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt    <= '0;
            shadow_q   <= '0;
            frame_tick <= 1'b0;
        end else begin
            pwm_cnt    <= pwm_cnt + PWM_W'(1);
            frame_tick <= (pwm_cnt == PWM_LAST);
            if (pwm_cnt == PWM_LAST) begin
                shadow_q <= ctrl_t'(pio_word);
            end
        end
    end

    // Free-running blink phase, independent of frame loads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    always_comb begin
        lit_c = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg_c[i] = SEG_OFF;
        end
        for (int i = 0; i < DIGITS; i++) begin
            lit_c[i] = shadow_q.en[i] & (pwm_cnt <= shadow_q.bright)
                       & ~(shadow_q.blink[i] & blink_ph);
            if (lit_c[i]) begin
                seg_c[i] = seg7(shadow_q.nib[NIB_W*i +: NIB_W]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex0 <= SEG_OFF;
            hex1 <= SEG_OFF;
            hex2 <= SEG_OFF;
            hex3 <= SEG_OFF;
        end else begin
            hex0 <= seg_c[0];
            hex1 <= seg_c[1];
            hex2 <= seg_c[2];
            hex3 <= seg_c[3];
        end
    end

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed bench for hex_display_driver with a short blink period.
// Each frame of 16 cycles is checked slot by slot against hand-computed segment values.
module tb_hex_display_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pio_word;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic        frame_tick;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    hex_display_driver #(.BLINK_DIV(8), .BLINK_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pio_word   (pio_word),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_off(input string tag, input logic ft_exp);
        chk({tag, " hex0"}, hex0, 7'h7F);
        chk({tag, " hex1"}, hex1, 7'h7F);
        chk({tag, " hex2"}, hex2, 7'h7F);
        chk({tag, " hex3"}, hex3, 7'h7F);
        chk({tag, " frame_tick"}, {6'b0, frame_tick}, {6'b0, ft_exp});
    endtask

    // Reset mid-frame, release, and expect the first load exactly 16 cycles later
    task automatic reset_and_sync(input string tag);
        repeat (5) @(negedge clk);
        pio_word = 32'h0FFF_FFFF;
        reset_n  = 1'b0;
        #1;
        chk_all_off({tag, " async"}, 1'b0);
        repeat (3) @(negedge clk);
        chk_all_off({tag, " held"}, 1'b0);
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk_all_off($sformatf("%s rel%0d", tag, k), (k == 16));
        end
    endtask

    // Checks one frame following a frame_tick; pio_word changes mid-frame to next_word
    task automatic check_frame(input string tag,
                               input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3,
                               input logic [3:0] en, input logic [3:0] bl,
                               input int br, input logic [31:0] next_word);
        logic [6:0] on  [4];
        logic [6:0] obs [4];
        logic [6:0] exp;
        on = '{s0, s1, s2, s3};
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            obs = '{hex0, hex1, hex2, hex3};
            for (int i = 0; i < 4; i++) begin
                exp = (en[i] && (k <= br) && !(bl[i] && (k >= 8))) ? on[i] : 7'h7F;
                chk($sformatf("%s k%0d hex%0d", tag, k, i), obs[i], exp);
            end
            chk($sformatf("%s k%0d frame_tick", tag, k), {6'b0, frame_tick},
                {6'b0, (k == 15)});
            if (k == 4) pio_word = next_word;
        end
    endtask

    initial begin
        reset_n  = 1'b1;
        pio_word = 32'h0FFF_FFFF;

        reset_and_sync("t1");
        check_frame("t1blink", 7'h0E, 7'h0E, 7'h0E, 7'h0E, 4'hF, 4'hF, 15, 32'h0F0F_1234);
        check_frame("t2", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF, 4'h0, 15, 32'h0F01_0000);

        for (int n = 0; n < 16; n++) begin
            logic [31:0] nxt;
            nxt = (n < 15) ? (32'h0F01_0000 | 32'(n + 1)) : 32'h030F_8888;
            check_frame($sformatf("t3 n%0d", n), seg_tab[n], 7'h40, 7'h40, 7'h40,
                        4'h1, 4'h0, 15, nxt);
        end

        check_frame("t4b3", 7'h00, 7'h00, 7'h00, 7'h00, 4'hF, 4'h0, 3, 32'h000F_8888);
        check_frame("t4b0", 7'h00, 7'h00, 7'h00, 7'h00, 4'hF, 4'h0, 0, 32'h0F2F_AAAA);
        check_frame("t6a",  7'h08, 7'h08, 7'h08, 7'h08, 4'hF, 4'h2, 15, 32'h0F2F_AAAA);
        check_frame("t6b",  7'h08, 7'h08, 7'h08, 7'h08, 4'hF, 4'h2, 15, 32'hF52E_C0DE);
        check_frame("t6en", 7'h03, 7'h21, 7'h40, 7'h46, 4'hE, 4'h2, 5, 32'h0FFF_FFFF);

        reset_and_sync("rst2");
        check_frame("t1again", 7'h0E, 7'h0E, 7'h0E, 7'h0E, 4'hF, 4'hF, 15, 32'h0FFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
